// File: rtl/traffic_injector_pkg.sv
// traffic_injector_pkg
//   Shared definitions for the per-router traffic injector: FSM state encoding,
//   flit type codes and helpers that give field widths and bit offsets. Offsets
//   are functions rather than constants because they depend on the injector
//   parameters; each user turns them into localparams at elaboration time.
//
//   Flit layout, MSB first:
//     type[2] | src[ROUTER_W] | dest[ROUTER_W] | vc[VC_W] | idx[LEN_W] | zero pad
//
//   Descriptor layout as stored in the FIFO, MSB first:
//     cycle[CYCLE_W] | dest[ROUTER_W] | vc[VC_W] | len[LEN_W]
package traffic_injector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } inj_state_e;

  localparam int FLIT_TYPE_W = 2;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY     = 2'b00;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD     = 2'b01;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL     = 2'b10;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEADTAIL = 2'b11;

  // Number of meaningful header bits at the top of a flit.
  function automatic int flit_hdr_width(input int router_w, input int vc_w, input int len_w);
    return FLIT_TYPE_W + 2 * router_w + vc_w + len_w;
  endfunction

  // Width of one packed descriptor entry.
  function automatic int desc_width(input int cycle_w, input int router_w,
                                    input int vc_w, input int len_w);
    return cycle_w + router_w + vc_w + len_w;
  endfunction

  // Flit field LSB positions, counted down from the MSB end of the flit.
  function automatic int flit_type_lsb(input int flit_w);
    return flit_w - FLIT_TYPE_W;
  endfunction

  function automatic int flit_src_lsb(input int flit_w, input int router_w);
    return flit_type_lsb(flit_w) - router_w;
  endfunction

  function automatic int flit_dest_lsb(input int flit_w, input int router_w);
    return flit_src_lsb(flit_w, router_w) - router_w;
  endfunction

  function automatic int flit_vc_lsb(input int flit_w, input int router_w, input int vc_w);
    return flit_dest_lsb(flit_w, router_w) - vc_w;
  endfunction

  function automatic int flit_idx_lsb(input int flit_w, input int router_w,
                                      input int vc_w, input int len_w);
    return flit_vc_lsb(flit_w, router_w, vc_w) - len_w;
  endfunction

endpackage

// File: rtl/traffic_injector_desc_fifo.sv
// desc_fifo
//   Synchronous show-ahead FIFO holding packet descriptors. rdata always shows
//   the oldest entry while empty is low. Push while full and pop while empty are
//   ignored, so callers may present raw request strobes. A push and a pop in the
//   same cycle are both honoured and leave the count unchanged.
//
// Ports
//   clk    in   posedge clock
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write wdata when not full
//   wdata  in   WIDTH  entry to write
//   pop    in   discard the head entry when not empty
//   rdata  out  WIDTH  head entry (valid while !empty)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
module desc_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8   // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/traffic_injector.sv
// traffic_injector
//   Per-router source stage. Packet descriptors are queued in a FIFO; the head
//   descriptor is held until the global cycle reaches its injection time, then
//   segmented into head/body/tail flits, one per cycle while the router accepts.
//   Descriptors leave strictly in order: a later descriptor with an earlier
//   injection time waits behind the current one.
//
// Ports
//   clk         in   posedge clock
//   rst         in   synchronous active-high reset; aborts any packet in flight
//   load_valid  in   descriptor offered
//   load_ready  out  descriptor FIFO not full
//   load_cycle  in   CYCLE_W   earliest injection cycle
//   load_dest   in   ROUTER_W  destination router
//   load_vc     in   VC_W      virtual channel
//   load_len    in   LEN_W     packet length in flits (0 behaves as 1)
//   in_cycle    in   CYCLE_W   global simulation cycle
//   can_inject  in   router accepts a flit this cycle
//   inj_valid   out  registered; high the cycle after a flit is produced
//   inj_flit    out  FLIT_W    registered flit; holds its value when not valid
//   busy        out  FIFO non-empty or a descriptor is being handled
//   pkt_sent    out  16        completed packets (tail emitted), wraps
module traffic_injector
  import traffic_injector_pkg::*;
#(
  parameter int SRC_ID     = 0,
  parameter int ROUTER_W   = 4,
  parameter int VC_W       = 2,
  parameter int LEN_W      = 4,
  parameter int CYCLE_W    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FLIT_W     = 32   // >= 2 + 2*ROUTER_W + VC_W + LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CYCLE_W-1:0]  load_cycle,
  input  logic [ROUTER_W-1:0] load_dest,
  input  logic [VC_W-1:0]     load_vc,
  input  logic [LEN_W-1:0]    load_len,
  input  logic [CYCLE_W-1:0]  in_cycle,
  input  logic                can_inject,
  output logic                inj_valid,
  output logic [FLIT_W-1:0]   inj_flit,
  output logic                busy,
  output logic [15:0]         pkt_sent
);

  localparam int DESC_W   = desc_width(CYCLE_W, ROUTER_W, VC_W, LEN_W);
  localparam int TYPE_LSB = flit_type_lsb(FLIT_W);
  localparam int SRC_LSB  = flit_src_lsb(FLIT_W, ROUTER_W);
  localparam int DEST_LSB = flit_dest_lsb(FLIT_W, ROUTER_W);
  localparam int VC_LSB   = flit_vc_lsb(FLIT_W, ROUTER_W, VC_W);
  localparam int IDX_LSB  = flit_idx_lsb(FLIT_W, ROUTER_W, VC_W, LEN_W);

  localparam logic [ROUTER_W-1:0] SRC_BITS = ROUTER_W'(SRC_ID);

  // ---------------------------------------------------------------------------
  // Descriptor FIFO
  // ---------------------------------------------------------------------------
  logic [DESC_W-1:0]   fifo_wdata, fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_pop;

  logic [CYCLE_W-1:0]  d_cycle;
  logic [ROUTER_W-1:0] d_dest;
  logic [VC_W-1:0]     d_vc;
  logic [LEN_W-1:0]    d_len;

  assign fifo_wdata = {load_cycle, load_dest, load_vc, load_len};
  assign {d_cycle, d_dest, d_vc, d_len} = fifo_rdata;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign load_ready = !fifo_full;

  desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (load_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Segmentation FSM
  // ---------------------------------------------------------------------------
  inj_state_e          state;
  logic [CYCLE_W-1:0]  cur_cycle;
  logic [ROUTER_W-1:0] cur_dest;
  logic [VC_W-1:0]     cur_vc;
  logic [LEN_W-1:0]    cur_len;   // already normalised: never 0
  logic [LEN_W-1:0]    idx;       // index of the last flit produced
  logic [LEN_W-1:0]    next_idx;
  logic                cycle_ok;
  logic                single;
  logic                next_is_tail;

  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
  assign busy         = (state != ST_IDLE) || !fifo_empty;
  assign cycle_ok     = (in_cycle >= cur_cycle);
  assign single       = (cur_len == LEN_W'(1));
  assign next_idx     = idx + 1'b1;
  assign next_is_tail = (next_idx == cur_len - 1'b1);

  function automatic logic [FLIT_W-1:0] fmt_flit(
    input logic [FLIT_TYPE_W-1:0] ftype,
    input logic [ROUTER_W-1:0]    fdest,
    input logic [VC_W-1:0]        fvc,
    input logic [LEN_W-1:0]       fidx
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: FLIT_TYPE_W] = ftype;
    f[SRC_LSB  +: ROUTER_W]    = SRC_BITS;
    f[DEST_LSB +: ROUTER_W]    = fdest;
    f[VC_LSB   +: VC_W]        = fvc;
    f[IDX_LSB  +: LEN_W]       = fidx;
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_cycle <= '0;
      cur_dest  <= '0;
      cur_vc    <= '0;
      cur_len   <= '0;
      idx       <= '0;
      inj_valid <= 1'b0;
      inj_flit  <= '0;
      pkt_sent  <= '0;
    end else begin
      // Valid is a one-cycle pulse per produced flit; the flit register holds.
      inj_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_cycle <= d_cycle;
            cur_dest  <= d_dest;
            cur_vc    <= d_vc;
            cur_len   <= (d_len == '0) ? LEN_W'(1) : d_len;
            idx       <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cycle_ok && can_inject) begin
            inj_valid <= 1'b1;
            idx       <= '0;
            if (single) begin
              inj_flit <= fmt_flit(FLIT_HEADTAIL, cur_dest, cur_vc, '0);
              pkt_sent <= pkt_sent + 16'd1;
              state    <= ST_IDLE;
            end else begin
              inj_flit <= fmt_flit(FLIT_HEAD, cur_dest, cur_vc, '0);
              state    <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (can_inject) begin
            inj_valid <= 1'b1;
            idx       <= next_idx;
            if (next_is_tail) begin
              inj_flit <= fmt_flit(FLIT_TAIL, cur_dest, cur_vc, next_idx);
              pkt_sent <= pkt_sent + 16'd1;
              state    <= ST_IDLE;
            end else begin
              inj_flit <= fmt_flit(FLIT_BODY, cur_dest, cur_vc, next_idx);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
